// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared types and widths for the cache memory arbiter.
package cache_arbiter_pkg;
   localparam int CLINE_W = 256;
   localparam int OFFSET_W = 5;
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, SERVE_PF} arb_state_t;
   typedef enum logic [1:0] {PORT_I, PORT_D, PORT_PF} arb_port_t;
endpackage

// File: rtl/cache_arbiter_select.sv
// arb_select: picks the next requester; D/I ties go to whoever did not win last, PF only when both are quiet.
module arb_select
   import cache_arbiter_pkg::*;
(
   input  logic      i_req,
   input  logic      d_req,
   input  logic      pf_req,
   input  logic      last_grant,
   output arb_port_t port,
   output logic      valid
);
   // last_grant is 1 when D was the most recent D/I winner
   always_comb begin
      port = (i_req && d_req) ? (last_grant ? PORT_I : PORT_D) :
             d_req ? PORT_D : i_req ? PORT_I : PORT_PF;
      valid = i_req | d_req | pf_req;
   end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory port among I-cache, D-cache and prefetcher with a 4-state FSM.
module cache_arbiter
   import cache_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_read,
   input  logic [31:0]        i_address,
   output logic [CLINE_W-1:0] i_rdata,
   output logic               i_resp,
   input  logic               d_read,
   input  logic               d_write,
   input  logic [31:0]        d_address,
   input  logic [CLINE_W-1:0] d_wdata,
   output logic [CLINE_W-1:0] d_rdata,
   output logic               d_resp,
   input  logic               pf_read,
   input  logic [31:0]        pf_address,
   output logic [CLINE_W-1:0] pf_rdata,
   output logic               pf_resp,
   output logic               mem_read,
   output logic               mem_write,
   output logic [31:0]        mem_address,
   output logic [CLINE_W-1:0] mem_wdata,
   input  logic [CLINE_W-1:0] mem_rdata,
   input  logic               mem_resp,
   output logic [7:0]         pf_starve_cnt
);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
   arb_state_t state, state_n;
   arb_port_t  sel;
   logic       sel_valid, last_grant;
   arb_select u_sel (
      .i_req(i_read), .d_req(d_read | d_write), .pf_req(pf_read),
      .last_grant(last_grant), .port(sel), .valid(sel_valid)
   );
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;
   assign pf_rdata = mem_rdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b0;
         pf_starve_cnt <= 8'd0;
      end else begin
         state <= state_n;
         if (state == IDLE && sel_valid && sel != PORT_PF)
            last_grant <= (sel == PORT_D);
         if (state == IDLE && pf_read)
            pf_starve_cnt <= (sel == PORT_PF) ? 8'd0 :
                             (pf_starve_cnt == 8'hFF) ? pf_starve_cnt : pf_starve_cnt + 8'd1;
      end
   end
   // a pending writeback blocks the D read until the write has been acknowledged
   always_comb begin
      state_n     = state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = 32'd0;
      mem_wdata   = '0;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      pf_resp     = 1'b0;
      case (state)
         IDLE: if (sel_valid)
            state_n = (sel == PORT_D) ? SERVE_D : (sel == PORT_I) ? SERVE_I : SERVE_PF;
         SERVE_I: begin
            mem_read    = i_read;
            mem_address = i_address & LINE_MASK;
            i_resp      = mem_resp;
         end
         SERVE_D: begin
            mem_write   = d_write;
            mem_read    = d_read & ~d_write;
            mem_address = d_address & LINE_MASK;
            mem_wdata   = d_wdata;
            d_resp      = mem_resp;
         end
         SERVE_PF: begin
            mem_read    = pf_read;
            mem_address = pf_address & LINE_MASK;
            pf_resp     = mem_resp;
         end
         default: state_n = IDLE;
      endcase
      if (state != IDLE && mem_resp) state_n = IDLE;
   end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus random traffic checked against a transaction-level arbiter model.
module tb_cache_arbiter;
   import cache_arbiter_pkg::*;
   logic clk = 1'b0, rst;
   logic i_read, i_resp, d_read, d_write, d_resp, pf_read, pf_resp;
   logic mem_read, mem_write, mem_resp;
   logic [31:0] i_address, d_address, pf_address, mem_address;
   logic [255:0] i_rdata, d_rdata, pf_rdata, d_wdata, mem_wdata, mem_rdata;
   logic [7:0] pf_starve_cnt;
   int errors = 0, checks = 0;
   int owner = -1;
   bit last_d = 0;
   int starve = 0;
   logic e_mread, e_mwrite, e_iresp, e_dresp, e_presp;
   logic [31:0] e_addr;
   logic [255:0] e_wdata;
   always #5 clk = ~clk;
   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pf_starve_cnt(pf_starve_cnt)
   );
   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction
   function automatic logic [31:0] line(input logic [31:0] a);
      return (a / 32) * 32;
   endfunction
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // checks this cycle's outputs against the model, then advances the model across one edge
   task automatic cyc();
      int nxt;
      #1;
      {e_mread, e_mwrite, e_iresp, e_dresp, e_presp} = '0;
      e_addr = 32'd0;
      e_wdata = '0;
      if (owner == 0) begin
         e_mread = i_read; e_addr = line(i_address); e_iresp = mem_resp;
      end else if (owner == 1) begin
         e_mwrite = d_write; e_mread = d_read && !d_write; e_addr = line(d_address);
         e_wdata = d_wdata; e_dresp = mem_resp;
      end else if (owner == 2) begin
         e_mread = pf_read; e_addr = line(pf_address); e_presp = mem_resp;
      end
      chk("mem_read", 256'(mem_read), 256'(e_mread));
      chk("mem_write", 256'(mem_write), 256'(e_mwrite));
      chk("mem_address", 256'(mem_address), 256'(e_addr));
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("i_resp", 256'(i_resp), 256'(e_iresp));
      chk("d_resp", 256'(d_resp), 256'(e_dresp));
      chk("pf_resp", 256'(pf_resp), 256'(e_presp));
      chk("i_rdata", i_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
      chk("pf_rdata", pf_rdata, mem_rdata);
      chk("pf_starve_cnt", 256'(pf_starve_cnt), 256'(starve));
      if (rst) begin
         owner = -1; last_d = 0; starve = 0;
      end else if (owner < 0) begin
         if (i_read && (d_read || d_write)) nxt = last_d ? 0 : 1;
         else if (d_read || d_write) nxt = 1;
         else if (i_read) nxt = 0;
         else if (pf_read) nxt = 2;
         else nxt = -1;
         if (pf_read) starve = (nxt == 2) ? 0 : (starve < 255 ? starve + 1 : 255);
         if (nxt == 0 || nxt == 1) last_d = (nxt == 1);
         owner = nxt;
      end else if (mem_resp) owner = -1;
      @(posedge clk);
      @(negedge clk);
   endtask
   // requesters retire whatever the model says was acknowledged last cycle
   task automatic retire();
      if (e_iresp) i_read = 0;
      if (e_dresp) begin
         if (d_write) d_write = 0;
         else d_read = 0;
      end
      if (e_presp) pf_read = 0;
   endtask
   task automatic finish_txn();
      mem_resp = 1; mem_rdata = rnd256();
      cyc();
      mem_resp = 0;
      retire();
   endtask
   initial begin
      rst = 1; {i_read, d_read, d_write, pf_read, mem_resp} = '0;
      i_address = 0; d_address = 0; pf_address = 0; d_wdata = '0; mem_rdata = '0;
      @(posedge clk);
      @(negedge clk);
      cyc();
      rst = 0;
      cyc();
      // single I miss with delayed memory response
      i_read = 1; i_address = 32'h0000_1234;
      cyc();
      #1 chk("s24_mread", 256'(mem_read), 256'(1));
      chk("s24_addr", 256'(mem_address), 256'(32'h0000_1220));
      cyc(); cyc(); cyc();
      mem_resp = 1; mem_rdata = {8{32'hCAFE_F00D}};
      #1 chk("s24_iresp", 256'(i_resp), 256'(1));
      chk("s24_rdata", i_rdata, {8{32'hCAFE_F00D}});
      cyc();
      mem_resp = 0; retire();
      cyc();
      // two ties in sequence: D, then the waiting I, then D again
      i_read = 1; i_address = 32'h0000_4000; d_read = 1; d_address = 32'h0000_8040;
      cyc();
      #1 chk("s25_first_d", 256'(mem_address), 256'(32'h0000_8040));
      finish_txn();
      cyc();
      #1 chk("s25_then_i", 256'(mem_address), 256'(32'h0000_4000));
      finish_txn();
      i_read = 1; d_read = 1;
      cyc();
      #1 chk("s25_d_again", 256'(mem_address), 256'(32'h0000_8040));
      finish_txn();
      cyc();
      finish_txn();
      cyc();
      // prefetch starved behind three I transactions
      pf_read = 1; pf_address = 32'h0001_003F; i_read = 1;
      for (int t = 0; t < 3; t++) begin
         cyc();
         mem_resp = 1; cyc(); mem_resp = 0;
      end
      #1 chk("s26_starve3", 256'(pf_starve_cnt), 256'(3));
      i_read = 0;
      cyc();
      #1 chk("s26_pf_grant", 256'(mem_address), 256'(32'h0001_0020));
      chk("s26_cleared", 256'(pf_starve_cnt), 256'(0));
      finish_txn();
      cyc();
      // combined write+read: writeback first
      d_read = 1; d_write = 1; d_address = 32'h0000_2222; d_wdata = {8{32'hA5A5_A5A5}};
      cyc();
      #1 chk("s27_mwrite", 256'(mem_write), 256'(1));
      chk("s27_wdata", mem_wdata, {8{32'hA5A5_A5A5}});
      finish_txn();
      cyc();
      #1 chk("s27_read", 256'(mem_read), 256'(1));
      finish_txn();
      cyc();
      // reset during SERVE_D, then a stray memory response in IDLE
      d_read = 1; d_address = 32'h0000_3300;
      cyc(); cyc();
      rst = 1; cyc(); rst = 0; d_read = 0;
      #1 chk("s28_mread0", 256'(mem_read), 256'(0));
      mem_resp = 1;
      #1 chk("s29_no_dresp", 256'(d_resp), 256'(0));
      cyc();
      mem_resp = 0;
      cyc();
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         retire();
         rst = ($urandom % 60 == 0);
         if (!i_read && $urandom % 4 == 0) begin i_read = 1; i_address = $urandom; end
         if (!d_read && !d_write && $urandom % 4 == 0) begin
            d_read = $urandom % 2; d_write = !d_read || ($urandom % 2 == 1);
            d_address = $urandom; d_wdata = rnd256();
         end
         if (!pf_read && $urandom % 3 == 0) begin pf_read = 1; pf_address = $urandom; end
         mem_resp = ($urandom % 3 == 0);
         mem_rdata = rnd256();
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The I-cache port SHALL be: i_read in 1 miss read request; i_address in 32 line address; i_rdata out 256 line data; i_resp out 1 done pulse.
REQ-003 The D-cache port SHALL be: d_read in 1; d_write in 1 writeback request; d_address in 32; d_wdata in 256; d_rdata out 256; d_resp out 1.
REQ-004 The prefetcher port SHALL be: pf_read in 1; pf_address in 32; pf_rdata out 256; pf_resp out 1.
REQ-005 The memory port SHALL be: mem_read out 1; mem_write out 1; mem_address out 32; mem_wdata out 256; mem_rdata in 256; mem_resp in 1.

Function
REQ-006 The FSM SHALL have states IDLE, SERVE_I, SERVE_D, SERVE_PF.
REQ-007 In IDLE, mem_read, mem_write and all *_resp SHALL be 0.
REQ-008 The grant SHALL be decided in IDLE from that cycle's requests, with the FSM entering the serve state on the next edge, so there is 1 cycle of request-to-mem_read/mem_write latency.
REQ-009 D versus I priority SHALL be round-robin: a 1-bit last_grant register holds the last D/I winner, the other wins on a tie, and last_grant resets to I so D wins the first tie.
REQ-010 The prefetcher SHALL be granted only when i_read=0 and d_read=0 and d_write=0 in IDLE.
REQ-011 In SERVE_x, mem_address SHALL equal the served address with bits [4:0] forced to 0, mem_read SHALL equal that requester's read request, and mem_write SHALL be 1 only in SERVE_D with d_write=1.
REQ-012 If d_read and d_write are both 1, write SHALL take precedence and d_read SHALL be served afterwards.
REQ-013 mem_wdata SHALL equal d_wdata in SERVE_D, else 0.
REQ-014 On mem_resp=1 in SERVE_x, the block SHALL pulse x_resp=1 combinationally in the same cycle, present mem_rdata on x_rdata, and return to IDLE on the next edge.
REQ-015 All *_rdata outputs SHALL continuously reflect mem_rdata, since consumers sample only while their resp is high.
REQ-016 Every transaction SHALL be followed by at least one IDLE cycle, with no back-to-back grants.
REQ-017 Requesters SHALL hold request and address stable until their resp; a request dropped mid-transaction SHALL still complete with its resp pulse issued.
REQ-018 mem_resp in IDLE SHALL be ignored and produce no *_resp.
REQ-019 The block SHALL count consecutive prefetch-denied IDLE cycles (8-bit saturating) as the debug output pf_starve_cnt out 8, clearing it on a PF grant.

Reset
REQ-020 rst=1 SHALL force, on the next edge, state=IDLE, last_grant=I and pf_starve_cnt=0, with all outputs 0.
REQ-021 rst asserted mid-transaction SHALL abandon that transaction without issuing a resp; the memory side is reset by the same rst.

Structure
REQ-022 A shared package SHALL hold arb_state_t (4-value enum), arb_port_t (I/D/PF), CLINE_W=256 and OFFSET_W=5.
REQ-023 Priority selection MAY be a combinational sub-module arb_select (inputs: requests and last_grant; output: arb_port_t plus valid); the FSM stays in cache_arbiter.

Verification
REQ-024 Scenario: i_read=1, addr 0x0000_1234, mem_resp after 4 cycles -> mem_read at cycle 1, mem_address=0x0000_1220, i_resp one cycle with i_rdata=mem_rdata, then IDLE.
REQ-025 Scenario: i_read and d_read rise together twice in sequence -> grants are D then I, then D again on the next tie.
REQ-026 Scenario: pf_read=1 with i_read held 1 for 3 transactions -> PF is not granted and pf_starve_cnt increments; PF is granted once i_read=0 and the count clears.
REQ-027 Scenario: d_read=1 and d_write=1, d_wdata=0xA5..A5 -> write first with mem_write=1 and mem_wdata=0xA5..A5 and d_resp, then IDLE, then read with d_resp.
REQ-028 Scenario: rst pulsed during SERVE_D before mem_resp -> next cycle state IDLE with all outputs 0; a later stray mem_resp produces no resp.
REQ-029 Scenario: mem_resp=1 in IDLE -> no *_resp asserted.
